mc_maindec: RTL and testbench



---
 rtl/mc_ctrl_pkg.sv | 61 ++++++
 rtl/mc_ctrl_outdec.sv | 81 ++++++++
 rtl/mc_maindec.sv | 95 +++++++++
 tb/tb_mc_maindec.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
// Optional feature macro: MC_MAINDEC_BNE_EN (adds the BNEEX state and branchne).
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ORIEX   = 4'd10,
    ANDIEX  = 4'd11,
    IWB     = 4'd12,
    JEX     = 4'd13
`ifdef MC_MAINDEC_BNE_EN
    ,
    BNEEX   = 4'd14
`endif
  } statetype;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_OR    = 3'b011;
  localparam logic [2:0] ALUOP_AND   = 3'b100;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
`ifdef MC_MAINDEC_BNE_EN
    logic       branchne;
`endif
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       zeroimm;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore output decoder: maps the controller state to the full control bundle.
// Optional feature macro: MC_MAINDEC_BNE_EN.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  statetype state_i,
  output ctrl_t    ctrl_o
);

  // Every control defaults to inactive / add; each state raises only what it needs
  always_comb begin
    ctrl_o       = '0;
    ctrl_o.aluop = ALUOP_ADD;
    case (state_i)
      FETCH: begin
        ctrl_o.irwrite = 1'b1;
        ctrl_o.pcwrite = 1'b1;
        ctrl_o.alusrcb = 2'b01;
      end
      DECODE: ctrl_o.alusrcb = 2'b11;
      MEMADR: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = 2'b10;
      end
      MEMRD: ctrl_o.iord = 1'b1;
      MEMWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memtoreg = 1'b1;
      end
      MEMWR: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.memwrite = 1'b1;
      end
      RTYPEEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      RTYPEWB: begin
        ctrl_o.regdst   = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      BEQEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.aluop   = ALUOP_SUB;
        ctrl_o.branch  = 1'b1;
        ctrl_o.pcsrc   = 2'b01;
      end
`ifdef MC_MAINDEC_BNE_EN
      BNEEX: begin
        ctrl_o.alusrca  = 1'b1;
        ctrl_o.aluop    = ALUOP_SUB;
        ctrl_o.branchne = 1'b1;
        ctrl_o.pcsrc    = 2'b01;
      end
`endif
      ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = 2'b10;
      end
      ORIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = 2'b10;
        ctrl_o.zeroimm = 1'b1;
        ctrl_o.aluop   = ALUOP_OR;
      end
      ANDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = 2'b10;
        ctrl_o.zeroimm = 1'b1;
        ctrl_o.aluop   = ALUOP_AND;
      end
      IWB: ctrl_o.regwrite = 1'b1;
      JEX: begin
        ctrl_o.pcwrite = 1'b1;
        ctrl_o.pcsrc   = 2'b10;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle MIPS main controller: state register, next-state logic, reset gating.
// Optional feature macro: MC_MAINDEC_BNE_EN (bne support and branchne port).
module mc_maindec
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       pcwrite,
  output logic       branch,
`ifdef MC_MAINDEC_BNE_EN
  output logic       branchne,
`endif
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zeroimm,
  output logic [1:0] pcsrc,
  output logic [2:0] aluop
);

  statetype state_q, state_d;
  statetype dec_state;
  ctrl_t    ctrl;

  // State register; reset returns to FETCH from any state
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state: decode dispatches on op, MEMADR re-reads op to split lw/sw
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
`ifdef MC_MAINDEC_BNE_EN
          OP_BNE:       state_d = BNEEX;
`endif
          OP_ADDI:      state_d = ADDIEX;
          OP_ORI:       state_d = ORIEX;
          OP_ANDI:      state_d = ANDIEX;
          OP_J:         state_d = JEX;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = IWB;
      ORIEX:   state_d = IWB;
      ANDIEX:  state_d = IWB;
      default: state_d = FETCH;
    endcase
  end

  // During reset the outputs show FETCH values regardless of the held state
  assign dec_state = reset ? FETCH : state_q;

  mc_ctrl_outdec u_outdec (
    .state_i (dec_state),
    .ctrl_o  (ctrl)
  );

  // Output drive; architectural write enables are suppressed while reset is high
  always_comb begin
    pcwrite  = ctrl.pcwrite  & ~reset;
    irwrite  = ctrl.irwrite  & ~reset;
    memwrite = ctrl.memwrite & ~reset;
    regwrite = ctrl.regwrite & ~reset;
    branch   = ctrl.branch;
`ifdef MC_MAINDEC_BNE_EN
    branchne = ctrl.branchne;
`endif
    iord     = ctrl.iord;
    regdst   = ctrl.regdst;
    memtoreg = ctrl.memtoreg;
    alusrca  = ctrl.alusrca;
    alusrcb  = ctrl.alusrcb;
    zeroimm  = ctrl.zeroimm;
    pcsrc    = ctrl.pcsrc;
    aluop    = ctrl.aluop;
  end

endmodule

// File: tb/tb_mc_maindec.sv
// Self-checking bench for mc_maindec: expected per-cycle output vectors are
// queued as each instruction is started and popped one per cycle.
module tb_mc_maindec;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg;
  logic       regwrite, alusrca, zeroimm;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] aluop;
`ifdef MC_MAINDEC_BNE_EN
  logic       branchne;
`endif

  mc_maindec dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .pcwrite  (pcwrite),
    .branch   (branch),
`ifdef MC_MAINDEC_BNE_EN
    .branchne (branchne),
`endif
    .iord     (iord),
    .memwrite (memwrite),
    .irwrite  (irwrite),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .regwrite (regwrite),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .zeroimm  (zeroimm),
    .pcsrc    (pcsrc),
    .aluop    (aluop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed vector: pcwrite branch iord memwrite irwrite regdst memtoreg
  // regwrite alusrca alusrcb[1:0] zeroimm pcsrc[1:0] aluop[2:0]
  logic [16:0] obs;
  assign obs = {pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg,
                regwrite, alusrca, alusrcb, zeroimm, pcsrc, aluop};

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3,
                 S_MEMWB = 4, S_MEMWR = 5, S_RTYPEEX = 6, S_RTYPEWB = 7,
                 S_BEQEX = 8, S_ADDIEX = 9, S_ORIEX = 10, S_ANDIEX = 11,
                 S_IWB = 12, S_JEX = 13, S_BNEEX = 14, S_RSTGATED = 15;

  int checks = 0;
  int failures = 0;

  logic [16:0] exp_q[$];
  string       nm_q[$];
  logic [16:0] e;
  string       nm;

  function automatic logic [16:0] mk(input bit pcw, input bit br, input bit ird,
                                     input bit mw, input bit irw, input bit rd,
                                     input bit m2r, input bit rw, input bit asa,
                                     input bit [1:0] asb, input bit zi,
                                     input bit [1:0] pcs, input bit [2:0] aop);
    return {pcw, br, ird, mw, irw, rd, m2r, rw, asa, asb, zi, pcs, aop};
  endfunction

  function automatic logic [16:0] exp_of(input int s);
    case (s)
      S_FETCH:    return mk(1,0,0,0,1,0,0,0,0,2'b01,0,2'b00,3'b000);
      S_DECODE:   return mk(0,0,0,0,0,0,0,0,0,2'b11,0,2'b00,3'b000);
      S_MEMADR:   return mk(0,0,0,0,0,0,0,0,1,2'b10,0,2'b00,3'b000);
      S_MEMRD:    return mk(0,0,1,0,0,0,0,0,0,2'b00,0,2'b00,3'b000);
      S_MEMWB:    return mk(0,0,0,0,0,0,1,1,0,2'b00,0,2'b00,3'b000);
      S_MEMWR:    return mk(0,0,1,1,0,0,0,0,0,2'b00,0,2'b00,3'b000);
      S_RTYPEEX:  return mk(0,0,0,0,0,0,0,0,1,2'b00,0,2'b00,3'b010);
      S_RTYPEWB:  return mk(0,0,0,0,0,1,0,1,0,2'b00,0,2'b00,3'b000);
      S_BEQEX:    return mk(0,1,0,0,0,0,0,0,1,2'b00,0,2'b01,3'b001);
      S_ADDIEX:   return mk(0,0,0,0,0,0,0,0,1,2'b10,0,2'b00,3'b000);
      S_ORIEX:    return mk(0,0,0,0,0,0,0,0,1,2'b10,1,2'b00,3'b011);
      S_ANDIEX:   return mk(0,0,0,0,0,0,0,0,1,2'b10,1,2'b00,3'b100);
      S_IWB:      return mk(0,0,0,0,0,0,0,1,0,2'b00,0,2'b00,3'b000);
      S_JEX:      return mk(1,0,0,0,0,0,0,0,0,2'b00,0,2'b10,3'b000);
      S_BNEEX:    return mk(0,0,0,0,0,0,0,0,1,2'b00,0,2'b01,3'b001);
      S_RSTGATED: return mk(0,0,0,0,0,0,0,0,0,2'b01,0,2'b00,3'b000);
      default:    return '0;
    endcase
  endfunction

  task automatic push(input int s, input string n);
    exp_q.push_back(exp_of(s));
    nm_q.push_back(n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    op    = 6'b100011;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (obs !== exp_of(S_RSTGATED)) begin
      failures++;
      $display("FAIL reset_outputs: got %b want %b", obs, exp_of(S_RSTGATED));
    end
    reset = 1'b0; #1;
  endtask

  task automatic test_lw();
    op = 6'b100011;
    push(S_FETCH, "lw_fetch");   push(S_DECODE, "lw_decode");
    push(S_MEMADR, "lw_memadr"); push(S_MEMRD, "lw_memrd");
    push(S_MEMWB, "lw_memwb");   push(S_FETCH, "lw_back_fetch");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL %s: got %b want %b", nm, obs, e); end
      if (exp_q.size() != 0) begin @(negedge clk); #1; end
    end
  endtask

  task automatic test_rtype();
    op = 6'b000000;
    push(S_FETCH, "r_fetch");     push(S_DECODE, "r_decode");
    push(S_RTYPEEX, "r_ex");      push(S_RTYPEWB, "r_wb");
    push(S_FETCH, "r_back_fetch");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL %s: got %b want %b", nm, obs, e); end
      if (exp_q.size() != 0) begin @(negedge clk); #1; end
    end
  endtask

  task automatic test_imm(input logic [5:0] opc, input int ex_state, input string tag);
    op = opc;
    push(S_FETCH, {tag, "_fetch"}); push(S_DECODE, {tag, "_decode"});
    push(ex_state, {tag, "_ex"});   push(S_IWB, {tag, "_iwb"});
    push(S_FETCH, {tag, "_back_fetch"});
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL %s: got %b want %b", nm, obs, e); end
      if (exp_q.size() != 0) begin @(negedge clk); #1; end
    end
  endtask

  task automatic test_branch_jump();
    op = 6'b000100;
    push(S_FETCH, "beq_fetch"); push(S_DECODE, "beq_decode");
    push(S_BEQEX, "beq_ex");    push(S_FETCH, "beq_back_fetch");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL %s: got %b want %b", nm, obs, e); end
      if (exp_q.size() != 0) begin @(negedge clk); #1; end
    end
    op = 6'b000010;
    push(S_FETCH, "j_fetch"); push(S_DECODE, "j_decode");
    push(S_JEX, "j_ex");      push(S_FETCH, "j_back_fetch");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL %s: got %b want %b", nm, obs, e); end
      if (exp_q.size() != 0) begin @(negedge clk); #1; end
    end
  endtask

  task automatic test_illegal(input logic [5:0] opc, input string tag);
    op = opc;
    push(S_FETCH, {tag, "_fetch"}); push(S_DECODE, {tag, "_decode"});
    push(S_FETCH, {tag, "_back_fetch"});
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL %s: got %b want %b", nm, obs, e); end
      if (exp_q.size() != 0) begin @(negedge clk); #1; end
    end
  endtask

  task automatic test_reset_midinstr();
    op = 6'b101011;
    push(S_FETCH, "sw_fetch");   push(S_DECODE, "sw_decode");
    push(S_MEMADR, "sw_memadr"); push(S_MEMWR, "sw_memwr");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL %s: got %b want %b", nm, obs, e); end
      if (exp_q.size() != 0) begin @(negedge clk); #1; end
    end
    reset = 1'b1; #1;
    checks++;
    if (memwrite !== 1'b0 || obs !== exp_of(S_RSTGATED)) begin
      failures++;
      $display("FAIL rst_in_memwr: got %b want %b", obs, exp_of(S_RSTGATED));
    end
    @(negedge clk); reset = 1'b0; #1;
    checks++;
    if (obs !== exp_of(S_FETCH)) begin
      failures++;
      $display("FAIL rst_then_fetch: got %b want %b", obs, exp_of(S_FETCH));
    end
    @(negedge clk); #1;
    checks++;
    if (obs !== exp_of(S_DECODE)) begin
      failures++;
      $display("FAIL rst_then_decode: got %b want %b", obs, exp_of(S_DECODE));
    end
    @(negedge clk); #1;
    checks++;
    if (obs !== exp_of(S_MEMADR)) begin
      failures++;
      $display("FAIL rst_then_memadr: got %b want %b", obs, exp_of(S_MEMADR));
    end
    // let the restarted sw finish so the next test starts from FETCH
    @(negedge clk); #1;
    @(negedge clk); #1;
  endtask

  task automatic test_back_to_back();
    op = 6'b001000;
    push(S_FETCH, "b2b_addi_fetch"); push(S_DECODE, "b2b_addi_decode");
    push(S_ADDIEX, "b2b_addi_ex");   push(S_IWB, "b2b_addi_iwb");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL %s: got %b want %b", nm, obs, e); end
      @(negedge clk); #1;
    end
    op = 6'b101011;
    push(S_FETCH, "b2b_sw_fetch"); push(S_DECODE, "b2b_sw_decode");
    push(S_MEMADR, "b2b_sw_memadr"); push(S_MEMWR, "b2b_sw_memwr");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL %s: got %b want %b", nm, obs, e); end
      @(negedge clk); #1;
    end
    op = 6'b000010;
    push(S_FETCH, "b2b_j_fetch"); push(S_DECODE, "b2b_j_decode");
    push(S_JEX, "b2b_j_ex");      push(S_FETCH, "b2b_j_back_fetch");
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL %s: got %b want %b", nm, obs, e); end
      if (exp_q.size() != 0) begin @(negedge clk); #1; end
    end
  endtask

`ifdef MC_MAINDEC_BNE_EN
  task automatic test_bne();
    bit bne_q[$];
    bit be;
    op = 6'b000101;
    push(S_FETCH, "bne_fetch"); bne_q.push_back(1'b0);
    push(S_DECODE, "bne_decode"); bne_q.push_back(1'b0);
    push(S_BNEEX, "bne_ex"); bne_q.push_back(1'b1);
    push(S_FETCH, "bne_back_fetch"); bne_q.push_back(1'b0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); nm = nm_q.pop_front(); be = bne_q.pop_front();
      checks++;
      if (obs !== e || branchne !== be) begin
        failures++;
        $display("FAIL %s: got %b/branchne=%b want %b/branchne=%b", nm, obs, branchne, e, be);
      end
      if (exp_q.size() != 0) begin @(negedge clk); #1; end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_imm(6'b001101, S_ORIEX, "ori");
    test_imm(6'b001100, S_ANDIEX, "andi");
    test_imm(6'b001000, S_ADDIEX, "addi");
    test_branch_jump();
    test_illegal(6'b111111, "illegal");
`ifdef MC_MAINDEC_BNE_EN
    test_bne();
`else
    test_illegal(6'b000101, "bne_disabled");
`endif
    test_reset_midinstr();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
